// File: rtl/mul_sequencer_if.sv
// ---------------------------------------------------------------------------
// mul_sequencer_if
//   Bundles the execute-stage signals exchanged between the pipeline and the
//   iterative multiplier.
//
//   Handshake: the pipeline raises start_E while a MUL sits in execute and
//   keeps it high for as long as stall_E is high. The multiplier accepts the
//   operation on the first clock edge where start_E is high and flush_E is
//   low while it is idle. done_E then pulses for exactly one cycle with
//   product_E valid, and stall_E is low in that cycle so the pipeline
//   advances. flush_E cancels any operation in flight, and no done_E follows.
//
//   Signals (pipeline = master, multiplier = slave):
//     start_E    master->slave  MUL instruction is in execute
//     flush_E    master->slave  synchronous cancel of the execute stage
//     srcA_E     master->slave  multiplicand
//     srcB_E     master->slave  multiplier
//     stall_E    slave->master  hold PC, IF/ID and ID/EX; bubble EX/MEM
//     busy       slave->master  iteration in progress
//     done_E     slave->master  one-cycle result-valid pulse
//     product_E  slave->master  low N bits of srcA_E * srcB_E
// ---------------------------------------------------------------------------
interface mul_sequencer_if #(
    parameter int N = 64
);
    logic         start_E;
    logic         flush_E;
    logic [N-1:0] srcA_E;
    logic [N-1:0] srcB_E;
    logic         stall_E;
    logic         busy;
    logic         done_E;
    logic [N-1:0] product_E;

    modport master (
        output start_E,
        output flush_E,
        output srcA_E,
        output srcB_E,
        input  stall_E,
        input  busy,
        input  done_E,
        input  product_E
    );

    modport slave (
        input  start_E,
        input  flush_E,
        input  srcA_E,
        input  srcB_E,
        output stall_E,
        output busy,
        output done_E,
        output product_E
    );
endinterface

// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// mul_sequencer
//   Iterative shift-add multiplier for the execute stage. It retires one
//   multiplier bit per cycle and stops early once no set multiplier bits
//   remain. The result is the low N bits of the product, which is the same
//   for signed and unsigned operands.
//
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset
//     bus          mul_sequencer_if.slave (start/flush/operands in,
//                  stall/busy/done/product out)
//     dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module mul_sequencer #(
    parameter int N = 64
) (
    input  logic            clk,
    input  logic            reset,
    mul_sequencer_if.slave  bus,
    output logic [1:0]      dbg_state_o
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [N-1:0]  mcand_q,   mcand_d;
    logic [N-1:0]  mplier_q,  mplier_d;
    logic [N-1:0]  acc_q,     acc_d;
    logic [CW-1:0] count_q,   count_d;
    logic [N-1:0]  product_q, product_d;

    logic          accept;
    logic [N-1:0]  acc_step;
    logic [N-1:0]  mcand_shift;
    logic [N-1:0]  mplier_shift;
    logic          last_step;

    // A start is taken only when it is not cancelled in the same cycle.
    assign accept = bus.start_E && !bus.flush_E;

    // One shift-add step, evaluated from the current registers.
    assign acc_step     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign mcand_shift  = mcand_q << 1;
    assign mplier_shift = mplier_q >> 1;

    // Stop when no set multiplier bits remain or the last bit was consumed.
    assign last_step = (mplier_shift == '0) || (count_q == CW'(N - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    mcand_d  = bus.srcA_E;
                    mplier_d = bus.srcB_E;
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                if (bus.flush_E) begin
                    // Cancelled: the previous product stays visible.
                    state_d = S_IDLE;
                end else begin
                    acc_d    = acc_step;
                    mcand_d  = mcand_shift;
                    mplier_d = mplier_shift;
                    count_d  = count_q + CW'(1);
                    if (last_step) begin
                        product_d = acc_step;
                        state_d   = S_DONE;
                    end
                end
            end

            S_DONE: begin
                // start_E still belongs to the retiring instruction here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The accepting cycle stalls combinationally so the MUL does not move on
    // before it has been latched. Reset masks it because start_E may be high.
    assign bus.stall_E   = !reset && (((state_q == S_IDLE) && accept) ||
                                      (state_q == S_RUN));
    assign bus.busy      = (state_q == S_RUN);
    assign bus.done_E    = (state_q == S_DONE);
    assign bus.product_E = product_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul_sequencer
//   Self-checking bench for mul_sequencer: directed cases followed by random
//   multiplications, compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mul_sequencer;

    localparam int N = 64;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    mul_sequencer_if #(.N(N)) bus ();

    mul_sequencer #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [N-1:0] exp_q[$];
    logic [N-1:0] last_product;
    int           n_checks = 0;
    int           n_pass   = 0;

    task automatic check(input string tag, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    // One RUN cycle per multiplier bit up to the highest set bit, minimum one.
    function automatic int ref_latency(input logic [N-1:0] b);
        int k;
        k = 1;
        for (int i = 0; i < N; i++)
            if (b[i]) k = i + 1;
        return k;
    endfunction

    function automatic logic [N-1:0] ref_product(input logic [N-1:0] a,
                                                 input logic [N-1:0] b);
        logic [N-1:0] p;
        p = a * b;
        return p;
    endfunction

    function automatic logic [N-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // ---------------- driver tasks ----------------
    // Starts a MUL in the next cycle and follows it to done_E, checking stall,
    // busy, latency and product. flush_at > 0 cancels it in that RUN cycle.
    // start_E is left high through DONE; end_mul drops it afterwards.
    task automatic do_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                          input int flush_at);
        int           k;
        int           cyc;
        bit           finished;
        logic [N-1:0] exp_p;
        k = ref_latency(b);
        exp_q.push_back(ref_product(a, b));
        @(negedge clk);
        bus.srcA_E  = a;
        bus.srcB_E  = b;
        bus.start_E = 1'b1;
        bus.flush_E = 1'b0;
        #1 check("stall_start", 64'(bus.stall_E), 64'd1);
        cyc = 0;
        finished = 1'b0;
        while (!finished && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (flush_at > 0 && cyc == flush_at) begin
                check("busy_before_flush", 64'(bus.busy), 64'd1);
                bus.flush_E = 1'b1;
                @(posedge clk);
                #1;
                bus.flush_E = 1'b0;
                bus.start_E = 1'b0;
                void'(exp_q.pop_back());
                @(negedge clk);
                check("flush_busy", 64'(bus.busy), 64'd0);
                check("flush_stall", 64'(bus.stall_E), 64'd0);
                check("flush_done", 64'(bus.done_E), 64'd0);
                check("flush_product", bus.product_E, last_product);
                finished = 1'b1;
            end else if (bus.done_E) begin
                exp_p = exp_q.pop_front();
                check("latency", 64'(cyc), 64'(k + 1));
                check("product", bus.product_E, exp_p);
                check("stall_done", 64'(bus.stall_E), 64'd0);
                check("busy_done", 64'(bus.busy), 64'd0);
                last_product = exp_p;
                finished = 1'b1;
            end else begin
                check("stall_run", 64'(bus.stall_E), 64'd1);
                check("busy_run", 64'(bus.busy), 64'd1);
                // Operand changes after acceptance must not matter.
                bus.srcA_E = rand64();
                bus.srcB_E = rand64();
            end
        end
        if (!finished) begin
            check("timeout", 64'(cyc), 64'(k + 1));
            void'(exp_q.pop_front());
        end
    endtask

    task automatic end_mul();
        @(posedge clk);
        #1 bus.start_E = 1'b0;
        @(negedge clk);
        check("idle_stall", 64'(bus.stall_E), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        check("idle_done", 64'(bus.done_E), 64'd0);
        check("idle_product", bus.product_E, last_product);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        bus.start_E  = 1'b0;
        bus.flush_E  = 1'b0;
        bus.srcA_E   = '0;
        bus.srcB_E   = '0;
        last_product = '0;

        #3;
        check("rst_product", bus.product_E, 64'd0);
        check("rst_stall", 64'(bus.stall_E), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done_E), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_stall", 64'(bus.stall_E), 64'd0);

        // Small operands, zero multiplier, maximum latency, -1 * -1.
        do_mul(64'd3, 64'd5, 0);                 end_mul();
        do_mul('1, 64'd0, 0);                    end_mul();
        do_mul(64'd3, 64'h8000_0000_0000_0000, 0); end_mul();
        do_mul('1, '1, 0);                       end_mul();

        // Flush in the 4th RUN cycle leaves the previous product (15).
        do_mul(64'd3, 64'd5, 0);                 end_mul();
        do_mul(64'd7, 64'h100, 4);
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_flush", 64'(bus.done_E), 64'd0);
        end
        check("product_kept", bus.product_E, 64'd15);

        // start together with flush is not accepted.
        bus.start_E = 1'b1;
        bus.flush_E = 1'b1;
        bus.srcA_E  = 64'd9;
        bus.srcB_E  = 64'd9;
        #1 check("startflush_stall", 64'(bus.stall_E), 64'd0);
        @(negedge clk);
        check("startflush_busy", 64'(bus.busy), 64'd0);
        bus.start_E = 1'b0;
        bus.flush_E = 1'b0;

        // Asynchronous reset in the middle of a long run.
        @(negedge clk);
        bus.srcA_E  = 64'd5;
        bus.srcB_E  = 64'h8000_0000_0000_0000;
        bus.start_E = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_run_busy", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_busy", 64'(bus.busy), 64'd0);
        check("async_stall", 64'(bus.stall_E), 64'd0);
        check("async_done", 64'(bus.done_E), 64'd0);
        check("async_product", bus.product_E, 64'd0);
        last_product = '0;
        @(negedge clk);
        bus.start_E = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rel_stall", 64'(bus.stall_E), 64'd0);
        check("rel_busy", 64'(bus.busy), 64'd0);

        // Back-to-back: second start taken in the IDLE cycle after DONE.
        do_mul(64'd2, 64'd2, 0);
        do_mul(64'd6, 64'd7, 0);
        end_mul();

        // Random operands with random multiplier widths and spacing.
        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] a;
            logic [N-1:0] b;
            a = rand64();
            b = rand64() >> $urandom_range(0, N - 1);
            do_mul(a, b, 0);
            if (i == 23 || $urandom_range(0, 1) == 1) end_mul();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Iterative shift-add multiplier sequencer for the pipelined LEGv8 core's execute stage. When a MUL instruction occupies execute, the block latches both register operands and computes the low N bits of their product, one multiplier bit per cycle, with early termination. It holds the pipeline with `stall_E` until the result is ready. It then presents the product for one cycle, and the execute-stage result mux selects it in place of the ALU result.

## Interface
- `N`, 64: operand and result width in bits.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start_E`  in  1  MUL instruction is in execute. Held high for as long as the pipeline is stalled.
- `flush_E`  in  1  synchronous cancel of the execute stage (branch mispredict / exception).
- `srcA_E`  in  N  multiplicand (`readData1_E`).
- `srcB_E`  in  N  multiplier (`readData2_E`).
- `stall_E`  out  1  freeze PC, IF/ID and ID/EX registers; bubble EX/MEM.
- `busy`  out  1  high while in the RUN state.
- `done_E`  out  1  one-cycle pulse: `product_E` is valid for the instruction in execute.
- `product_E`  out  N  low N bits of `srcA_E * srcB_E`. Registered; holds until the next accepted start.

## Operation
- **States:** IDLE, RUN, DONE. Internal registers:
  - `mcand` (N bits), `mplier` (N bits), `acc` (N bits).
  - `count` (log2 N bits).
- **Reset (asynchronous):**
  - State goes to IDLE.
  - `acc`, `product_E`, `mcand`, `mplier` and `count` clear to 0.
  - `done_E`, `busy` and `stall_E` are 0 while reset is high.
- **Priority:** reset, then flush, then normal operation.
- **IDLE:**
  - If `start_E` && !`flush_E`: load `mcand` = `srcA_E`, `mplier` = `srcB_E`, `acc` = 0, `count` = 0, and go to RUN.
  - Otherwise stay in IDLE.
- **RUN, one step per cycle:**
  - If `mplier[0]`, then `acc` += `mcand` (mod 2^N).
  - `mcand` <<= 1 and `mplier` >>= 1 (both logical shifts).
  - `count`++.
  - Go to DONE when the post-shift `mplier` is 0 or `count` == N-1. On that same edge, `product_E` takes the final accumulator value.
- **DONE:**
  - `done_E` = 1 and `stall_E` = 0, so the pipeline advances on this edge.
  - `start_E` is ignored, because it is still the same instruction.
  - Unconditional transition to IDLE.
- **`flush_E` in any state:** next state is IDLE. No `done_E` pulse follows, and `product_E` is unchanged. A flush in the same cycle as a start in IDLE means the operation is not accepted.
- **Outputs:**
  - `stall_E` = (IDLE && `start_E` && !`flush_E`) || RUN. It is combinational so the start cycle itself stalls.
  - `busy` = RUN.
  - `done_E` = DONE.
- **Arithmetic:** the low N bits are identical for signed and unsigned operands, so there is no sign handling. Overflow beyond N bits is discarded.

## Timing
- A start accepted at edge t (IDLE) gives k RUN cycles, where k = max(1, index of the highest set bit of `srcB_E` + 1).
  - The block is in DONE at cycle t+k+1 and back in IDLE at t+k+2.
  - `stall_E` is high for k+1 cycles: the start cycle plus the RUN cycles.
- **Latency bounds:**
  - Minimum, when `srcB_E` = 0 or 1: 1 RUN cycle, with `done_E` 2 cycles after start.
  - Maximum, when the multiplier MSB is set: N RUN cycles, with `done_E` N+1 cycles after start.
- **Back-to-back MULs:** the second start is accepted in the IDLE cycle after DONE. There is no throughput penalty beyond the latency.
- `srcA_E` and `srcB_E` are sampled only on the accepting edge. Changes during RUN have no effect.
- Reset asserted mid-RUN aborts immediately. The block is in IDLE on the first edge after reset is released, with `stall_E` = 0.

## Test plan
- **Small operands:** reset, then start with `srcA_E` = 3, `srcB_E` = 5.
  - Expect 3 RUN cycles with `stall_E` high for 4 cycles including the start cycle.
  - Expect `done_E` 4 cycles after start with `product_E` = 15, then IDLE with `stall_E` = 0.
- **Zero multiplier:** `srcA_E` = 0xFFFF_FFFF_FFFF_FFFF, `srcB_E` = 0.
  - Expect 1 RUN cycle and `done_E` at start+2 with `product_E` = 0.
- **Maximum latency, wrap:** `srcA_E` = 3, `srcB_E` = 0x8000_0000_0000_0000.
  - Expect 64 RUN cycles and `done_E` at start+65 with `product_E` = 0x8000_0000_0000_0000.
- **Signed equivalence:** `srcA_E` = `srcB_E` = 0xFFFF_FFFF_FFFF_FFFF (−1 × −1).
  - Expect `done_E` at start+65 with `product_E` = 1.
- **Flush:** previous `product_E` = 15. Start 7 × 0x100, then assert `flush_E` on the 4th RUN cycle.
  - Expect IDLE on the next cycle, no `done_E`, `product_E` still 15 and `stall_E` = 0.
  - Then assert `start_E` and `flush_E` together: the start must not be accepted (`stall_E` = 0, `busy` stays 0).
- **Reset and back-to-back:**
  - Assert reset asynchronously mid-RUN. Expect `busy`, `stall_E`, `done_E` and `product_E` all 0 before the next clock edge.
  - After release, run two back-to-back MULs (2 × 2, then 6 × 7). Expect `done_E` pulses with products 4 and 42, and the second start accepted in the IDLE cycle after the first DONE.
